// File: rtl/sdram_init_sequencer.sv
// DDR SDRAM power-up / mode-register sequencer that owns CKE and the pads until init completes.
// Define INIT_REFRESH_EN to add periodic auto-refresh with a REF_REQ/REF_GRANT handshake once running.
`ifndef PRCH
`define PRCH 3'b010
`endif
`ifndef MRST
`define MRST 3'b000
`endif
`ifndef ARSR
`define ARSR 3'b001
`endif
`ifndef NOOP
`define NOOP 3'b111
`endif

module sdram_init_sequencer #(
    parameter int                ADDR_W         = 13,
    parameter int                BANK_W         = 2,
    parameter int                POWERUP_CYCLES = 65536,
    parameter int                GAP_CYCLES     = 15,
    parameter int                SETTLE_CYCLES  = 256,
    parameter int                AREF_COUNT     = 2,
    parameter logic [ADDR_W-1:0] EMR_VAL        = 'h000,
    parameter logic [ADDR_W-1:0] MR_DLL_VAL     = 'h161,
    parameter logic [ADDR_W-1:0] MR_VAL         = 'h031,
    parameter int                REFI_CYCLES    = 1560
) (
    input  logic              CLK_n,
    input  logic              RST,
    output logic              CKE,
    output logic [2:0]        COMMAND_PIN,
    output logic [ADDR_W-1:0] ADDRESS_PIN,
    output logic [BANK_W-1:0] BANK_PIN,
    input  logic [2:0]        COMMAND_USER,
    input  logic [ADDR_W-1:0] ADDRESS_USER,
    input  logic [BANK_W-1:0] BANK_USER,
    output logic              RST_USER,
    input  logic              REINIT,
    output logic              REF_REQ,
    input  logic              REF_GRANT,
    output logic              HOLD_USER,
    output logic              REF_OVERRUN
);
    localparam int N_CMDS   = 5 + AREF_COUNT;
    localparam int HOLD_LEN = 3 * GAP_CYCLES + 2;
    localparam int MAX_A    = (POWERUP_CYCLES > SETTLE_CYCLES) ? POWERUP_CYCLES : SETTLE_CYCLES;
    localparam int MAX_B    = (GAP_CYCLES > HOLD_LEN) ? GAP_CYCLES : HOLD_LEN;
    localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;
    localparam int IDX_W    = $clog2(N_CMDS) + 1;
    localparam logic [ADDR_W-1:0] A10 = ADDR_W'(1) << 10;

    typedef enum logic [2:0] {S_PWRUP, S_GAP, S_ISSUE, S_SETTLE, S_RUN, S_RHOLD} state_t;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [BANK_W-1:0] bank;
    } pin_t;

    localparam pin_t PIN_IDLE = {`NOOP, {ADDR_W{1'b0}}, {BANK_W{1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              cke_q, cke_d;
    logic              rst_user_q, rst_user_d;
    pin_t              pin_q, pin_d;
    logic              user_sel;

    function automatic pin_t seq_cmd(input logic [IDX_W-1:0] idx);
        pin_t p;
        p.cmd  = `ARSR;
        p.addr = '0;
        p.bank = '0;
        if (idx == IDX_W'(0)) begin
            p.cmd  = `PRCH;
            p.addr = A10;
            p.bank = BANK_W'(1);
        end else if (idx == IDX_W'(1)) begin
            p.cmd  = `MRST;
            p.addr = EMR_VAL;
            p.bank = BANK_W'(1);
        end else if (idx == IDX_W'(2)) begin
            p.cmd  = `MRST;
            p.addr = MR_DLL_VAL;
        end else if (idx == IDX_W'(3)) begin
            p.cmd  = `PRCH;
            p.addr = A10;
        end else if (idx == IDX_W'(N_CMDS - 1)) begin
            p.cmd  = `MRST;
            p.addr = MR_VAL;
        end
        return p;
    endfunction

`ifdef INIT_REFRESH_EN
    localparam int TMR_W = $clog2(REFI_CYCLES) + 1;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ref_req_q, ref_req_d;
    logic             hold_q, hold_d;
    logic             ovr_q, ovr_d;
`endif

    always_ff @(posedge CLK_n) begin
        if (RST) begin
            state_q    <= S_PWRUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            cke_q      <= 1'b0;
            rst_user_q <= 1'b0;
            pin_q      <= PIN_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cke_q      <= cke_d;
            rst_user_q <= rst_user_d;
            pin_q      <= pin_d;
        end
    end

`ifdef INIT_REFRESH_EN
    always_ff @(posedge CLK_n) begin
        if (RST) begin
            tmr_q     <= '0;
            ref_req_q <= 1'b0;
            hold_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            ref_req_q <= ref_req_d;
            hold_q    <= hold_d;
            ovr_q     <= ovr_d;
        end
    end
`endif

    // Pin values are registered one cycle ahead: pin_d is what the pads show next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        cke_d      = cke_q;
        rst_user_d = rst_user_q;
        pin_d      = PIN_IDLE;
`ifdef INIT_REFRESH_EN
        ref_req_d  = ref_req_q;
        hold_d     = hold_q;
        ovr_d      = ovr_q;
        tmr_d      = '0;
        if (state_q == S_RUN || state_q == S_RHOLD) begin
            if (tmr_q == TMR_W'(REFI_CYCLES - 1)) begin
                if (ref_req_q || hold_q) ovr_d = 1'b1;
                else                     ref_req_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
`endif
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    cke_d   = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    pin_d   = seq_cmd(idx_q);
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (idx_q == IDX_W'(N_CMDS - 1)) begin
                    idx_d = '0;
                    if (SETTLE_CYCLES == 0) begin
                        state_d    = S_RUN;
                        rst_user_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_GAP;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    cnt_d      = '0;
                    rst_user_d = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (REINIT) begin
                    state_d    = S_GAP;
                    rst_user_d = 1'b0;
                    idx_d      = '0;
`ifdef INIT_REFRESH_EN
                    ref_req_d  = 1'b0;
                    ovr_d      = 1'b0;
                    tmr_d      = '0;
`endif
                end
`ifdef INIT_REFRESH_EN
                else if (ref_req_q && REF_GRANT) begin
                    state_d   = S_RHOLD;
                    ref_req_d = 1'b0;
                    hold_d    = 1'b1;
                end
`endif
            end
`ifdef INIT_REFRESH_EN
            S_RHOLD: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    pin_d.cmd  = `PRCH;
                    pin_d.addr = A10;
                end else if (cnt_q == CNT_W'(2 * GAP_CYCLES)) begin
                    pin_d.cmd = `ARSR;
                end else if (cnt_q == CNT_W'(HOLD_LEN - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hold_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef INIT_REFRESH_EN
    assign REF_REQ     = ref_req_q;
    assign HOLD_USER   = hold_q;
    assign REF_OVERRUN = ovr_q;
    assign user_sel    = rst_user_q & ~hold_q;
`else
    logic unused_refresh;
    assign unused_refresh = ^{REF_GRANT, 32'(REFI_CYCLES)};
    assign REF_REQ     = 1'b0;
    assign HOLD_USER   = 1'b0;
    assign REF_OVERRUN = 1'b0;
    assign user_sel    = rst_user_q;
`endif

    assign CKE         = cke_q;
    assign RST_USER    = rst_user_q;
    assign COMMAND_PIN = user_sel ? COMMAND_USER : pin_q.cmd;
    assign ADDRESS_PIN = user_sel ? ADDRESS_USER : pin_q.addr;
    assign BANK_PIN    = user_sel ? BANK_USER    : pin_q.bank;

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Bench for sdram_init_sequencer: random user traffic checked cycle by cycle against a schedule model.
`ifndef PRCH
`define PRCH 3'b010
`endif
`ifndef MRST
`define MRST 3'b000
`endif
`ifndef ARSR
`define ARSR 3'b001
`endif
`ifndef NOOP
`define NOOP 3'b111
`endif

module tb_sdram_init_sequencer;
    localparam int P    = 20;
    localparam int G    = 3;
    localparam int ST   = 5;
    localparam int AR   = 2;
    localparam int REFI = 50;
    localparam int AW   = 13;
    localparam int BW   = 2;
    localparam int N    = 5 + AR;
    localparam int LAST_OFS  = G + (N - 1) * (G + 1);
    localparam int RISE      = P + LAST_OFS + ST + 1;
    localparam int REQ1      = RISE + REFI;
    localparam int GRANT_AT  = REQ1 + 3;
    localparam int H0        = GRANT_AT + 1;
    localparam int HOLD_END  = H0 + 3 * G + 2;
    localparam int REQ2      = RISE + 2 * REFI;
    localparam int OVR_AT    = RISE + 3 * REFI;
    localparam int REINIT_AT = OVR_AT + 7;

    typedef struct packed {
        logic          cke;
        logic          rst_user;
        logic          req;
        logic          hold;
        logic          ovr;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [BW-1:0] bank;
    } obs_t;

    logic          CLK_n = 1'b0;
    logic          RST   = 1'b1;
    logic          CKE;
    logic [2:0]    COMMAND_PIN;
    logic [AW-1:0] ADDRESS_PIN;
    logic [BW-1:0] BANK_PIN;
    logic [2:0]    COMMAND_USER = `NOOP;
    logic [AW-1:0] ADDRESS_USER = '0;
    logic [BW-1:0] BANK_USER    = '0;
    logic          RST_USER;
    logic          REINIT    = 1'b0;
    logic          REF_REQ;
    logic          REF_GRANT = 1'b0;
    logic          HOLD_USER;
    logic          REF_OVERRUN;

    sdram_init_sequencer #(
        .ADDR_W(AW), .BANK_W(BW), .POWERUP_CYCLES(P), .GAP_CYCLES(G), .SETTLE_CYCLES(ST),
        .AREF_COUNT(AR), .EMR_VAL(13'h000), .MR_DLL_VAL(13'h161), .MR_VAL(13'h031),
        .REFI_CYCLES(REFI)
    ) dut (
        .CLK_n(CLK_n), .RST(RST), .CKE(CKE), .COMMAND_PIN(COMMAND_PIN),
        .ADDRESS_PIN(ADDRESS_PIN), .BANK_PIN(BANK_PIN), .COMMAND_USER(COMMAND_USER),
        .ADDRESS_USER(ADDRESS_USER), .BANK_USER(BANK_USER), .RST_USER(RST_USER),
        .REINIT(REINIT), .REF_REQ(REF_REQ), .REF_GRANT(REF_GRANT), .HOLD_USER(HOLD_USER),
        .REF_OVERRUN(REF_OVERRUN)
    );

    always #5 CLK_n = ~CLK_n;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2:0]    tab_cmd  [N];
    logic [AW-1:0] tab_addr [N];
    logic [BW-1:0] tab_bank [N];

    // Schedule model: sequence whose first NOOP gap starts at cycle s, CKE high from cke_at.
    function automatic obs_t expected(input int t, input int s, input int cke_at);
        obs_t e;
        int   k;
        e          = '0;
        e.cke      = (t >= cke_at);
        e.rst_user = (t >= s + LAST_OFS + ST + 1);
        e.cmd      = `NOOP;
        k          = t - s - G;
        if (k >= 0 && (k % (G + 1)) == 0 && (k / (G + 1)) < N) begin
            e.cmd  = tab_cmd[k / (G + 1)];
            e.addr = tab_addr[k / (G + 1)];
            e.bank = tab_bank[k / (G + 1)];
        end
        if (e.rst_user) begin
            e.cmd  = COMMAND_USER;
            e.addr = ADDRESS_USER;
            e.bank = BANK_USER;
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.cke      = CKE;
        o.rst_user = RST_USER;
        o.req      = REF_REQ;
        o.hold     = HOLD_USER;
        o.ovr      = REF_OVERRUN;
        o.cmd      = COMMAND_PIN;
        o.addr     = ADDRESS_PIN;
        o.bank     = BANK_PIN;
        return o;
    endfunction

    task automatic tick();
        @(posedge CLK_n);
        #1;
        cyc++;
    endtask

    task automatic drive_user();
        COMMAND_USER = 3'($urandom);
        ADDRESS_USER = AW'($urandom);
        BANK_USER    = BW'($urandom);
        REF_GRANT    = 1'($urandom);
    endtask

    task automatic restart();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        obs_t r, o;
        r     = '0;
        r.cmd = `NOOP;
        RST   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_user();
            #1;
            o = observed();
            n_tests++;
            if (o !== r) begin
                n_fail++;
                $display("FAIL reset_values iter=%0d got=%h exp=%h", i, o, r);
            end
        end
    endtask

    task automatic test_powerup_sequence();
        obs_t e, o;
        restart();
        for (int t = 0; t <= RISE + 6; t++) begin
            if (t > 0) tick();
            drive_user();
            REINIT = 1'b0;
            if (t == RISE) COMMAND_USER = `PRCH;
            #1;
            e = expected(cyc, P, P);
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL init_seq cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (t == RISE) begin
                n_tests++;
                if (COMMAND_PIN !== `PRCH) begin
                    n_fail++;
                    $display("FAIL handover_cmd cyc=%0d got=%b exp=%b", cyc, COMMAND_PIN, `PRCH);
                end
            end
        end
    endtask

    task automatic test_reinit();
        obs_t e, o;
        int   s, run_at, pulse_at;
        s      = P;
        run_at = RISE;
        for (int round = 0; round < 4; round++) begin
            pulse_at = (round == 0) ? run_at + 7 : run_at + int'($urandom_range(1, 6));
            while (cyc < pulse_at) begin
                tick();
                drive_user();
                REINIT = 1'b0;
                #1;
                e = expected(cyc, s, 0);
                o = observed();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reinit_run r=%0d cyc=%0d got=%h exp=%h", round, cyc, o, e);
                end
            end
            REINIT = 1'b1;
            s      = pulse_at + 1;
            run_at = s + LAST_OFS + ST + 1;
            while (cyc < run_at) begin
                tick();
                drive_user();
                REINIT = (cyc < run_at) && ($urandom_range(0, 3) == 0);
                #1;
                e = expected(cyc, s, 0);
                o = observed();
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL reinit_seq r=%0d cyc=%0d got=%h exp=%h", round, cyc, o, e);
                end
            end
        end
        REINIT = 1'b0;
    endtask

    task automatic test_rst_mid();
        obs_t e, o, r;
        r     = '0;
        r.cmd = `NOOP;
        restart();
        for (int t = 0; t <= 35; t++) begin
            if (t > 0) tick();
            drive_user();
            #1;
            e = expected(cyc, P, P);
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        drive_user();
        #1;
        o = observed();
        n_tests++;
        if (o !== r) begin
            n_fail++;
            $display("FAIL rst_mid_reset cyc=%0d got=%h exp=%h", cyc, o, r);
        end
        cyc = 0;
        for (int t = 1; t <= RISE + 3; t++) begin
            tick();
            drive_user();
            #1;
            e = expected(cyc, P, P);
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rst_mid_restart cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    task automatic test_refresh();
        obs_t e, o;
        int   s;
        restart();
        for (int t = 0; t <= REINIT_AT + 1; t++) begin
            if (t > 0) tick();
            drive_user();
            REINIT = 1'b0;
`ifdef INIT_REFRESH_EN
            REF_GRANT = (t == GRANT_AT);
            REINIT    = (t == H0 + 5) || (t == REINIT_AT);
`endif
            #1;
            s = P;
`ifdef INIT_REFRESH_EN
            if (cyc > REINIT_AT) s = REINIT_AT + 1;
`endif
            e = expected(cyc, s, P);
`ifdef INIT_REFRESH_EN
            e.req  = (cyc >= REQ1 && cyc <= GRANT_AT) || (cyc >= REQ2 && cyc <= REINIT_AT);
            e.hold = (cyc >= H0 && cyc < HOLD_END);
            e.ovr  = (cyc >= OVR_AT && cyc <= REINIT_AT);
            if (e.hold) begin
                e.cmd  = `NOOP;
                e.addr = '0;
                e.bank = '0;
                if (cyc == H0 + G) begin
                    e.cmd  = `PRCH;
                    e.addr = 13'h400;
                end
                if (cyc == H0 + 2 * G + 1) e.cmd = `ARSR;
            end
`endif
            o = observed();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL refresh cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        REINIT    = 1'b0;
        REF_GRANT = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            tab_cmd[i]  = `ARSR;
            tab_addr[i] = '0;
            tab_bank[i] = '0;
        end
        tab_cmd[0]   = `PRCH; tab_addr[0]   = 13'h400; tab_bank[0] = 2'd1;
        tab_cmd[1]   = `MRST; tab_addr[1]   = 13'h000; tab_bank[1] = 2'd1;
        tab_cmd[2]   = `MRST; tab_addr[2]   = 13'h161;
        tab_cmd[3]   = `PRCH; tab_addr[3]   = 13'h400;
        tab_cmd[N-1] = `MRST; tab_addr[N-1] = 13'h031;

        test_reset();
        test_powerup_sequence();
        test_reinit();
        test_rst_mid();
        test_refresh();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
